line_centroid_detector: RTL and testbench

- PCLK-domain producer of per-frame line-tracking results, feeding the system-clock LED/HEX display block.
- Classifies each incoming RGB565 camera pixel as "yellow" and accumulates the count and x-coordinate sum over a row band (ROI).
- At each frame end, divides the sum by the count to get the centroid x.
- Publishes frame_pulse, width, centroid_x and detected; the three data outputs are held stable across the pulse.

---
 rtl/line_follow_pkg.sv | 33 +++
 rtl/seq_udiv.sv | 90 +++++++++
 rtl/line_centroid_detector.sv | 220 ++++++++++++++++++++++
 tb/tb_line_centroid_detector.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/line_follow_pkg.sv
// Shared widths, RGB565 field positions, FSM encoding and saturating helpers
// for the line centroid detector.
package line_follow_pkg;

  localparam int SUM_W   = 32;
  localparam int CNT_W   = 20;
  localparam int COORD_W = 16;

  localparam int R_HI = 15;
  localparam int R_LO = 11;
  localparam int G_HI = 10;
  localparam int G_LO = 5;
  localparam int B_HI = 4;
  localparam int B_LO = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIV   = 2'd1,
    PULSE = 2'd2
  } state_e;

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [SUM_W-1:0] sat_add_sum(input logic [SUM_W-1:0] s,
                                                   input logic [COORD_W-1:0] x);
    logic [SUM_W:0] t;
    t = {1'b0, s} + {{(SUM_W + 1 - COORD_W){1'b0}}, x};
    return t[SUM_W] ? {SUM_W{1'b1}} : t[SUM_W-1:0];
  endfunction

endpackage

// File: rtl/seq_udiv.sv
// Restoring unsigned divider, one quotient bit per cycle; the start edge also
// performs the first step, so done pulses 32 cycles after start with quotient final.
module seq_udiv
  import line_follow_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [SUM_W-1:0] dividend,
  input  logic [CNT_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [SUM_W-1:0] quotient
);

  localparam logic [4:0] ITER_LAST = 5'(SUM_W - 1);

  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [4:0]       iter_q, iter_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [SUM_W-1:0] quo_q, quo_d;
  logic [CNT_W-1:0] dvs_q, dvs_d;

  logic             load;
  logic [CNT_W-1:0] rem_in;
  logic [SUM_W-1:0] quo_in;
  logic [CNT_W-1:0] dvs_in;
  logic [CNT_W:0]   trial;
  logic             fits;
  logic [CNT_W-1:0] rem_step;
  logic [SUM_W-1:0] quo_step;

  always_comb begin
    load     = start && !busy_q;
    rem_in   = load ? '0 : rem_q;
    quo_in   = load ? dividend : quo_q;
    dvs_in   = load ? divisor : dvs_q;
    // Dividend bits shift out of the top of quo while quotient bits shift in.
    trial    = {rem_in, quo_in[SUM_W-1]};
    fits     = trial >= {1'b0, dvs_in};
    rem_step = fits ? CNT_W'(trial - {1'b0, dvs_in}) : trial[CNT_W-1:0];
    quo_step = {quo_in[SUM_W-2:0], fits};

    busy_d = busy_q;
    done_d = 1'b0;
    iter_d = iter_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    if (load) begin
      busy_d = 1'b1;
      iter_d = 5'd1;
      rem_d  = rem_step;
      quo_d  = quo_step;
      dvs_d  = dvs_in;
    end else if (busy_q) begin
      rem_d  = rem_step;
      quo_d  = quo_step;
      iter_d = iter_q + 5'd1;
      if (iter_q == ITER_LAST) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      iter_q <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      iter_q <= iter_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign quotient = quo_q;

endmodule

// File: rtl/line_centroid_detector.sv
// Per-frame yellow-pixel centroid over a row band; results publish with a PULSE_LEN-cycle
// frame_pulse at T+1 (no pixels) or T+33 (after divide); a frame end while busy sets overrun.
module line_centroid_detector
  import line_follow_pkg::*;
#(
  parameter int ROI_Y0     = 0,
  parameter int ROI_Y1     = 479,
  parameter int R_MIN      = 20,
  parameter int G_MIN      = 40,
  parameter int B_MAX      = 10,
  parameter int MIN_PIXELS = 16,
  parameter int PULSE_LEN  = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               vsync,
  input  logic               href,
  input  logic               pixel_valid,
  input  logic [15:0]        pixel,
  output logic               frame_pulse,
  output logic [COORD_W-1:0] width,
  output logic [COORD_W-1:0] centroid_x,
  output logic               detected,
  output logic               overrun
);

  localparam logic [COORD_W-1:0] ROI_LO     = COORD_W'(ROI_Y0);
  localparam logic [COORD_W-1:0] ROI_SPAN   = COORD_W'(ROI_Y1 - ROI_Y0);
  localparam logic [4:0]         R_MIN_C    = 5'(R_MIN);
  localparam logic [5:0]         G_MIN_C    = 6'(G_MIN);
  localparam logic [4:0]         B_MAX_C    = 5'(B_MAX);
  localparam logic [CNT_W-1:0]   MIN_CNT    = CNT_W'(MIN_PIXELS);
  localparam logic [7:0]         PULSE_LAST = 8'(PULSE_LEN - 1);

  logic vsync_q, vsync_prev_q, href_q, href_prev_q, pix_vld_q;
  logic [15:0] pixel_q;

  logic [COORD_W-1:0] x_q, x_d, y_q, y_d, line_w_q, line_w_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SUM_W-1:0]   sum_q, sum_d;

  logic [CNT_W-1:0]   cnt_snap_q, cnt_snap_d;
  logic [COORD_W-1:0] line_w_snap_q, line_w_snap_d;

  state_e             state_q, state_d;
  logic [7:0]         pulse_cnt_q, pulse_cnt_d;
  logic               frame_pulse_q, frame_pulse_d;
  logic [COORD_W-1:0] width_q, width_d, centroid_q, centroid_d;
  logic               detected_q, detected_d, overrun_q, overrun_d;

  logic href_rise, href_fall, frame_end, pix_ok, in_roi, is_yellow, pulse_last;
  logic [COORD_W-1:0] x_base, line_w_upd, y_upd;
  logic [CNT_W-1:0]   cnt_acc;
  logic [SUM_W-1:0]   sum_acc;

  logic             div_start, div_busy, div_done;
  logic [SUM_W-1:0] div_quo;
  logic             div_unused;

  assign href_rise  = href_q & ~href_prev_q;
  assign href_fall  = ~href_q & href_prev_q;
  assign frame_end  = vsync_q & ~vsync_prev_q;
  assign pix_ok     = pix_vld_q & href_q & ~vsync_q;
  assign in_roi     = (y_q - ROI_LO) <= ROI_SPAN;
  assign is_yellow  = pix_ok && in_roi &&
                      (pixel_q[R_HI:R_LO] >= R_MIN_C) &&
                      (pixel_q[G_HI:G_LO] >= G_MIN_C) &&
                      (pixel_q[B_HI:B_LO] <= B_MAX_C);
  assign pulse_last = pulse_cnt_q == PULSE_LAST;

  // Pixel datapath; the *_acc / *_upd values include this cycle's update so a
  // pixel or line end coinciding with the frame end lands in the snapshot.
  always_comb begin
    x_base     = href_rise ? '0 : x_q;
    x_d        = pix_ok ? x_base + COORD_W'(1) : x_base;
    line_w_upd = href_fall ? x_q : line_w_q;
    y_upd      = href_fall ? y_q + COORD_W'(1) : y_q;
    cnt_acc    = cnt_q;
    sum_acc    = sum_q;
    if (is_yellow) begin
      cnt_acc = sat_inc_cnt(cnt_q);
      sum_acc = sat_add_sum(sum_q, x_base);
    end
    if (frame_end) begin
      cnt_d    = '0;
      sum_d    = '0;
      line_w_d = '0;
      y_d      = '0;
    end else begin
      cnt_d    = cnt_acc;
      sum_d    = sum_acc;
      line_w_d = line_w_upd;
      y_d      = y_upd;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (frame_end) state_d = (cnt_acc == '0) ? PULSE : DIV;
      DIV:     if (div_done) state_d = PULSE;
      PULSE:   if (pulse_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    frame_pulse_d = frame_pulse_q;
    width_d       = width_q;
    centroid_d    = centroid_q;
    detected_d    = detected_q;
    overrun_d     = overrun_q;
    pulse_cnt_d   = pulse_cnt_q;
    cnt_snap_d    = cnt_snap_q;
    line_w_snap_d = line_w_snap_q;
    div_start     = 1'b0;
    case (state_q)
      IDLE: begin
        if (frame_end) begin
          cnt_snap_d    = cnt_acc;
          line_w_snap_d = line_w_upd;
          if (cnt_acc == '0) begin
            frame_pulse_d = 1'b1;
            width_d       = line_w_upd;
            centroid_d    = '0;
            detected_d    = 1'b0;
            pulse_cnt_d   = '0;
          end else begin
            div_start = 1'b1;
          end
        end
      end
      DIV: begin
        if (div_done) begin
          frame_pulse_d = 1'b1;
          width_d       = line_w_snap_q;
          centroid_d    = div_quo[COORD_W-1:0];
          detected_d    = cnt_snap_q >= MIN_CNT;
          pulse_cnt_d   = '0;
        end
      end
      PULSE: begin
        if (pulse_last) frame_pulse_d = 1'b0;
        else            pulse_cnt_d   = pulse_cnt_q + 8'd1;
      end
      default: ;
    endcase
    if (frame_end && state_q != IDLE) overrun_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vsync_q       <= 1'b0;
      vsync_prev_q  <= 1'b0;
      href_q        <= 1'b0;
      href_prev_q   <= 1'b0;
      pix_vld_q     <= 1'b0;
      pixel_q       <= '0;
      x_q           <= '0;
      y_q           <= '0;
      line_w_q      <= '0;
      cnt_q         <= '0;
      sum_q         <= '0;
      cnt_snap_q    <= '0;
      line_w_snap_q <= '0;
      pulse_cnt_q   <= '0;
      frame_pulse_q <= 1'b0;
      width_q       <= '0;
      centroid_q    <= '0;
      detected_q    <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      vsync_q       <= vsync;
      vsync_prev_q  <= vsync_q;
      href_q        <= href;
      href_prev_q   <= href_q;
      pix_vld_q     <= pixel_valid;
      pixel_q       <= pixel;
      x_q           <= x_d;
      y_q           <= y_d;
      line_w_q      <= line_w_d;
      cnt_q         <= cnt_d;
      sum_q         <= sum_d;
      cnt_snap_q    <= cnt_snap_d;
      line_w_snap_q <= line_w_snap_d;
      pulse_cnt_q   <= pulse_cnt_d;
      frame_pulse_q <= frame_pulse_d;
      width_q       <= width_d;
      centroid_q    <= centroid_d;
      detected_q    <= detected_d;
      overrun_q     <= overrun_d;
    end
  end

  seq_udiv u_div (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (div_start),
    .dividend (sum_acc),
    .divisor  (cnt_acc),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quo)
  );

  // The quotient cannot exceed the largest x for unsaturated sums, so only the low half is published.
  assign div_unused = div_busy ^ (^div_quo[SUM_W-1:COORD_W]);

  assign frame_pulse = frame_pulse_q;
  assign width       = width_q;
  assign centroid_x  = centroid_q;
  assign detected    = detected_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_line_centroid_detector.sv
// Directed bench: drives camera frames and checks centroid, width, detected, pulse timing,
// ROI banding, overrun and mid-divide reset against hand-computed values.
module tb_line_centroid_detector;

  localparam logic [15:0] YEL = 16'hFFE0;

  logic        clk;
  logic        reset_n;
  logic        vsync, href, pixel_valid;
  logic [15:0] pixel;
  logic        frame_pulse, detected, overrun;
  logic [15:0] width, centroid_x;
  logic        r_frame_pulse, r_detected, r_overrun;
  logic [15:0] r_width, r_centroid_x;

  int n_cmp = 0;
  int n_err = 0;

  line_centroid_detector dut (
    .clk(clk), .reset_n(reset_n), .vsync(vsync), .href(href),
    .pixel_valid(pixel_valid), .pixel(pixel),
    .frame_pulse(frame_pulse), .width(width), .centroid_x(centroid_x),
    .detected(detected), .overrun(overrun)
  );

  line_centroid_detector #(.ROI_Y0(2), .ROI_Y1(2)) dut_roi (
    .clk(clk), .reset_n(reset_n), .vsync(vsync), .href(href),
    .pixel_valid(pixel_valid), .pixel(pixel),
    .frame_pulse(r_frame_pulse), .width(r_width), .centroid_x(r_centroid_x),
    .detected(r_detected), .overrun(r_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One line of npix pixels: colour c1 on x in [lo,hi], colour ce at x==xe, black elsewhere.
  task automatic send_line(input int npix, input int lo, input int hi, input logic [15:0] c1,
                           input int xe, input logic [15:0] ce);
    href = 1'b1;
    for (int x = 0; x < npix; x++) begin
      pixel_valid = 1'b1;
      pixel = (x == xe) ? ce : ((x >= lo && x <= hi) ? c1 : 16'h0000);
      @(negedge clk);
    end
    href = 1'b0;
    pixel_valid = 1'b0;
    pixel = 16'h0000;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_frame(input int nlines, input int lo, input int hi, input logic [15:0] c1,
                            input int xe, input logic [15:0] ce);
    for (int l = 0; l < nlines; l++) send_line(16, lo, hi, c1, xe, ce);
  endtask

  // Raises vsync; k is the cycle offset from T at which frame_pulse is first seen (-1 if never).
  // A nonzero second_rise produces another vsync rise at T+second_rise.
  task automatic run_frame_end(input int second_rise, output int k, output int len,
                               output logic stable, output logic [15:0] cx, output logic [15:0] w,
                               output logic det, output logic [15:0] rcx, output logic rdet);
    vsync = 1'b1;
    k = -1; len = 0; stable = 1'b1;
    cx = '0; w = '0; det = 1'b0; rcx = '0; rdet = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (second_rise > 0 && i == second_rise - 6) vsync = 1'b0;
      if (second_rise > 0 && i == second_rise - 1) vsync = 1'b1;
      if (frame_pulse === 1'b1) begin
        k = i;
        break;
      end
    end
    if (k >= 0) begin
      cx = centroid_x; w = width; det = detected; rcx = r_centroid_x; rdet = r_detected;
      len = 1;
      for (int j = 0; j < 20; j++) begin
        @(negedge clk);
        if (frame_pulse !== 1'b1) break;
        len++;
        if (centroid_x !== cx || width !== w || detected !== det) stable = 1'b0;
      end
    end
    vsync = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  int          k, len, pulses;
  logic        stable, det, rdet;
  logic [15:0] cx, w, rcx;

  initial begin
    reset_n = 1'b0; vsync = 1'b0; href = 1'b0; pixel_valid = 1'b0; pixel = 16'h0000;
    repeat (3) @(negedge clk);
    check("rst_pulse", {31'd0, frame_pulse}, 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_width", {16'd0, width}, 32'd0);
    check("rst_cx", {16'd0, centroid_x}, 32'd0);
    check("rst_det", {31'd0, detected}, 32'd0);
    check("rst_ovr", {31'd0, overrun}, 32'd0);
    check("rst_roi_pulse", {31'd0, r_frame_pulse}, 32'd0);

    // 4 lines x 16 px, yellow at x=4..7: cnt 16, sum 88 -> 5
    send_frame(4, 4, 7, YEL, -1, 16'h0000);
    run_frame_end(0, k, len, stable, cx, w, det, rcx, rdet);
    check("basic_latency", k, 33);
    check("basic_pulse_len", len, 4);
    check("basic_stable", {31'd0, stable}, 32'd1);
    check("basic_cx", {16'd0, cx}, 32'd5);
    check("basic_width", {16'd0, w}, 32'd16);
    check("basic_det", {31'd0, det}, 32'd1);
    check("basic_ovr", {31'd0, overrun}, 32'd0);

    // frame end with no completed line
    run_frame_end(0, k, len, stable, cx, w, det, rcx, rdet);
    check("noline_latency", k, 1);
    check("noline_width", {16'd0, w}, 32'd0);

    // no yellow pixels
    send_frame(4, 1, 0, YEL, -1, 16'h0000);
    run_frame_end(0, k, len, stable, cx, w, det, rcx, rdet);
    check("empty_latency", k, 1);
    check("empty_pulse_len", len, 4);
    check("empty_cx", {16'd0, cx}, 32'd0);
    check("empty_det", {31'd0, det}, 32'd0);
    check("empty_width", {16'd0, w}, 32'd16);

    // per-line bands: full 0..15 -> 120/16=7; ROI line 2 only x=8..11 -> 38/4=9
    send_line(16, 0, 3, YEL, -1, 16'h0000);
    send_line(16, 4, 7, YEL, -1, 16'h0000);
    send_line(16, 8, 11, YEL, -1, 16'h0000);
    send_line(16, 12, 15, YEL, -1, 16'h0000);
    run_frame_end(0, k, len, stable, cx, w, det, rcx, rdet);
    check("band_latency", k, 33);
    check("band_cx", {16'd0, cx}, 32'd7);
    check("band_det", {31'd0, det}, 32'd1);
    check("roi_cx", {16'd0, rcx}, 32'd9);
    check("roi_det", {31'd0, rdet}, 32'd0);

    // MIN_PIXELS threshold
    send_frame(15, 10, 10, YEL, -1, 16'h0000);
    run_frame_end(0, k, len, stable, cx, w, det, rcx, rdet);
    check("thr15_cx", {16'd0, cx}, 32'd10);
    check("thr15_det", {31'd0, det}, 32'd0);
    send_frame(16, 10, 10, YEL, -1, 16'h0000);
    run_frame_end(0, k, len, stable, cx, w, det, rcx, rdet);
    check("thr16_cx", {16'd0, cx}, 32'd10);
    check("thr16_det", {31'd0, det}, 32'd1);

    // B=10 at x=2 counts, B=11 at x=14 does not: 4/2 = 2
    send_frame(2, 2, 2, 16'hFFEA, 14, 16'hFFEB);
    run_frame_end(0, k, len, stable, cx, w, det, rcx, rdet);
    check("blue_latency", k, 33);
    check("blue_cx", {16'd0, cx}, 32'd2);
    check("blue_det", {31'd0, det}, 32'd0);

    // second frame end 10 cycles after the first
    send_frame(4, 4, 7, YEL, -1, 16'h0000);
    run_frame_end(10, k, len, stable, cx, w, det, rcx, rdet);
    check("ovr_latency", k, 33);
    check("ovr_cx", {16'd0, cx}, 32'd5);
    check("ovr_det", {31'd0, det}, 32'd1);
    check("ovr_flag", {31'd0, overrun}, 32'd1);
    pulses = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (frame_pulse === 1'b1) pulses++;
    end
    check("ovr_no_second_pulse", pulses, 0);

    // reset at T+15 while dividing
    send_frame(4, 4, 7, YEL, -1, 16'h0000);
    vsync = 1'b1;
    pulses = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (i == 15) begin
        reset_n = 1'b0;
        vsync = 1'b0;
      end
      if (i == 16) begin
        check("rstdiv_width", {16'd0, width}, 32'd0);
        check("rstdiv_cx", {16'd0, centroid_x}, 32'd0);
        check("rstdiv_det", {31'd0, detected}, 32'd0);
        check("rstdiv_ovr", {31'd0, overrun}, 32'd0);
      end
      if (i == 18) reset_n = 1'b1;
      if (frame_pulse === 1'b1) pulses++;
    end
    check("rstdiv_no_pulse", pulses, 0);

    send_frame(4, 4, 7, YEL, -1, 16'h0000);
    run_frame_end(0, k, len, stable, cx, w, det, rcx, rdet);
    check("post_rst_latency", k, 33);
    check("post_rst_cx", {16'd0, cx}, 32'd5);
    check("post_rst_width", {16'd0, w}, 32'd16);
    check("post_rst_det", {31'd0, det}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
